// File: rtl/int_clk_div_pkg.sv
// Shared types and helpers for the runtime-programmable integer clock divider.
// Optional odd-ratio 50% duty correction is enabled with INT_CLK_DIV_ODD_DUTY50_EN.
package int_clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BYPASS = 2'd2
  } state_t;

  // Ratios at or below this value select bypass (0 and 1 both mean divide-by-1).
  localparam int unsigned BYPASS_MAX = 1;

  function automatic int unsigned half_len(input int unsigned ratio);
    return ratio >> 1;
  endfunction

endpackage

// File: rtl/int_clk_div_clk_out_mux.sv
// Output clock select between divided flop and source clock, plus the optional
// negedge duty-correction flop (INT_CLK_DIV_ODD_DUTY50_EN); kept apart for clock-cell mapping.
module clk_out_mux (
  input  logic clk,
`ifdef INT_CLK_DIV_ODD_DUTY50_EN
  input  logic rst_n,
  input  logic odd,
`endif
  input  logic bypass,
  input  logic div_q,
  output logic div_clk
);

`ifdef INT_CLK_DIV_ODD_DUTY50_EN
  logic div_neg_q;

  // Half-cycle delayed copy stretches the high phase by half a source cycle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) div_neg_q <= 1'b0;
    else        div_neg_q <= div_q;
  end

  assign div_clk = bypass ? clk : (div_q | (odd & div_neg_q));
`else
  assign div_clk = bypass ? clk : div_q;
`endif

endmodule

// File: rtl/int_clk_div.sv
// Runtime-programmable integer clock divider: single synchronous counter, bypass
// for ratio 0/1, changes applied only at period boundaries. Macro: INT_CLK_DIV_ODD_DUTY50_EN.
module int_clk_div
  import int_clk_div_pkg::*;
#(
  parameter int RATIO_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clk_en,
  input  logic [RATIO_W-1:0] i_div_ratio,
  output logic               o_div_clk,
  output logic               o_locked,
  output state_t             dbg_state
);

  localparam logic [RATIO_W-1:0] ONE     = RATIO_W'(1);
  localparam logic [RATIO_W-1:0] BYP_MAX = RATIO_W'(BYPASS_MAX);

  state_t             state, state_nxt;
  logic [RATIO_W-1:0] cnt, cnt_nxt;
  logic [RATIO_W-1:0] act_ratio, act_ratio_nxt;
  logic [RATIO_W-1:0] hi_len, cnt_inc;
  logic               div_q, div_q_nxt;
  logic               period_end, req_bypass;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      act_ratio <= '0;
      div_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      act_ratio <= act_ratio_nxt;
      div_q     <= div_q_nxt;
    end
  end

  assign hi_len     = RATIO_W'(half_len(32'(act_ratio)));
  assign cnt_inc    = cnt + ONE;
  assign period_end = (cnt == (act_ratio - ONE));
  assign req_bypass = (i_div_ratio <= BYP_MAX);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    act_ratio_nxt = act_ratio;
    div_q_nxt     = div_q;
    case (state)
      ST_IDLE: begin
        cnt_nxt   = '0;
        div_q_nxt = 1'b0;
        if (i_clk_en) begin
          act_ratio_nxt = i_div_ratio;
          if (req_bypass) begin
            state_nxt = ST_BYPASS;
          end else begin
            state_nxt = ST_RUN;
            div_q_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (period_end) begin
          // Ratio always loads at the boundary, even when leaving for IDLE.
          cnt_nxt       = '0;
          act_ratio_nxt = i_div_ratio;
          if (i_clk_en) begin
            div_q_nxt = 1'b1;
            state_nxt = req_bypass ? ST_BYPASS : ST_RUN;
          end else begin
            div_q_nxt = 1'b0;
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt   = cnt_inc;
          div_q_nxt = (cnt_inc < hi_len);
        end
      end
      ST_BYPASS: begin
        cnt_nxt = '0;
        if (!i_clk_en) begin
          state_nxt = ST_IDLE;
          div_q_nxt = 1'b0;
        end else begin
          // Every source cycle is a period boundary in bypass.
          act_ratio_nxt = i_div_ratio;
          if (!req_bypass) begin
            state_nxt = ST_RUN;
            div_q_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        div_q_nxt = 1'b0;
      end
    endcase
  end

  assign o_locked  = ((state == ST_RUN) || (state == ST_BYPASS)) && (act_ratio == i_div_ratio);
  assign dbg_state = state;

  clk_out_mux u_clk_out_mux (
    .clk     (i_clk),
`ifdef INT_CLK_DIV_ODD_DUTY50_EN
    .rst_n   (i_rst_n),
    .odd     ((state == ST_RUN) && act_ratio[0]),
`endif
    .bypass  (state == ST_BYPASS),
    .div_q   (div_q),
    .div_clk (o_div_clk)
  );

endmodule

// File: tb/tb_int_clk_div.sv
// Directed self-checking bench for int_clk_div (default and INT_CLK_DIV_ODD_DUTY50_EN builds).
module tb_int_clk_div;
  import int_clk_div_pkg::*;

  localparam int RATIO_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clk_en;
  logic [RATIO_W-1:0] div_ratio;
  logic               div_clk;
  logic               locked;
  state_t             dbg_state;

  int checks = 0;
  int errors = 0;

  int_clk_div #(.RATIO_W(RATIO_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clk_en    (clk_en),
    .i_div_ratio (div_ratio),
    .o_div_clk   (div_clk),
    .o_locked    (locked),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // Expected output for phase ph of an n-cycle period; at_neg selects the low half of the source cycle.
  function automatic logic exp_out(input int ph, input int n, input bit at_neg);
    int hi;
    hi = n / 2;
    if (ph < hi) return 1'b1;
`ifdef INT_CLK_DIV_ODD_DUTY50_EN
    if (!at_neg && (n % 2 == 1) && (ph == hi)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic half();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    clk_en    = 1'b0;
    div_ratio = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b0; div_ratio = 8'd4;
    #1;
    checks++; if (div_clk !== 1'b0) begin errors++; $display("FAIL reset_out got=%b exp=0", div_clk); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (div_clk !== 1'b0) begin errors++; $display("FAIL idle_out got=%b exp=0", div_clk); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL idle_locked got=%b exp=0", locked); end
  endtask

  task automatic test_ratio4();
    do_reset();
    div_ratio = 8'd4; clk_en = 1'b1;
    #1;
    checks++; if (div_clk !== 1'b0) begin errors++; $display("FAIL r4_pre got=%b exp=0", div_clk); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL r4_pre_locked got=%b exp=0", locked); end
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++; if (div_clk !== exp_out(k % 4, 4, 0)) begin errors++; $display("FAIL r4_pos k=%0d got=%b exp=%b", k, div_clk, exp_out(k % 4, 4, 0)); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL r4_locked k=%0d got=%b exp=1", k, locked); end
      half();
      checks++; if (div_clk !== exp_out(k % 4, 4, 1)) begin errors++; $display("FAIL r4_neg k=%0d got=%b exp=%b", k, div_clk, exp_out(k % 4, 4, 1)); end
    end
  endtask

  task automatic test_ratio5();
    do_reset();
    div_ratio = 8'd5; clk_en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      checks++; if (div_clk !== exp_out(k % 5, 5, 0)) begin errors++; $display("FAIL r5_pos k=%0d got=%b exp=%b", k, div_clk, exp_out(k % 5, 5, 0)); end
      half();
      checks++; if (div_clk !== exp_out(k % 5, 5, 1)) begin errors++; $display("FAIL r5_neg k=%0d got=%b exp=%b", k, div_clk, exp_out(k % 5, 5, 1)); end
    end
  endtask

  task automatic test_ratio_change();
    do_reset();
    div_ratio = 8'd6; clk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (div_clk !== exp_out(k, 6, 0)) begin errors++; $display("FAIL rc6_pos k=%0d got=%b exp=%b", k, div_clk, exp_out(k, 6, 0)); end
      half();
    end
    div_ratio = 8'd3;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rc_unlock got=%b exp=0", locked); end
    for (int k = 3; k < 6; k++) begin
      tick();
      checks++; if (div_clk !== exp_out(k, 6, 0)) begin errors++; $display("FAIL rc6_tail k=%0d got=%b exp=%b", k, div_clk, exp_out(k, 6, 0)); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rc_locked_low k=%0d got=%b exp=0", k, locked); end
      half();
    end
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++; if (div_clk !== exp_out(k % 3, 3, 0)) begin errors++; $display("FAIL rc3_pos k=%0d got=%b exp=%b", k, div_clk, exp_out(k % 3, 3, 0)); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rc_relock k=%0d got=%b exp=1", k, locked); end
      half();
      checks++; if (div_clk !== exp_out(k % 3, 3, 1)) begin errors++; $display("FAIL rc3_neg k=%0d got=%b exp=%b", k, div_clk, exp_out(k % 3, 3, 1)); end
    end
  endtask

  task automatic test_bypass();
    do_reset();
    div_ratio = 8'd4; clk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      half();
    end
    div_ratio = 8'd1;
    for (int k = 2; k < 4; k++) begin
      tick();
      checks++; if (div_clk !== exp_out(k, 4, 0)) begin errors++; $display("FAIL byp_tail k=%0d got=%b exp=%b", k, div_clk, exp_out(k, 4, 0)); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL byp_unlocked k=%0d got=%b exp=0", k, locked); end
      half();
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      checks++; if (div_clk !== 1'b1) begin errors++; $display("FAIL byp_hi j=%0d got=%b exp=1", j, div_clk); end
      checks++; if (dbg_state !== ST_BYPASS) begin errors++; $display("FAIL byp_state j=%0d got=%0d exp=%0d", j, dbg_state, ST_BYPASS); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL byp_locked j=%0d got=%b exp=1", j, locked); end
      half();
      checks++; if (div_clk !== 1'b0) begin errors++; $display("FAIL byp_lo j=%0d got=%b exp=0", j, div_clk); end
    end
    div_ratio = 8'd2;
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL byp2_unlock got=%b exp=0", locked); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (div_clk !== exp_out(k % 2, 2, 0)) begin errors++; $display("FAIL r2_pos k=%0d got=%b exp=%b", k, div_clk, exp_out(k % 2, 2, 0)); end
      checks++; if (dbg_state !== ST_RUN) begin errors++; $display("FAIL r2_state k=%0d got=%0d exp=%0d", k, dbg_state, ST_RUN); end
      half();
      checks++; if (div_clk !== exp_out(k % 2, 2, 1)) begin errors++; $display("FAIL r2_neg k=%0d got=%b exp=%b", k, div_clk, exp_out(k % 2, 2, 1)); end
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    div_ratio = 8'd8; clk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      half();
    end
    clk_en = 1'b0;
    for (int k = 2; k < 8; k++) begin
      tick();
      checks++; if (div_clk !== exp_out(k, 8, 0)) begin errors++; $display("FAIL drop_pos k=%0d got=%b exp=%b", k, div_clk, exp_out(k, 8, 0)); end
      half();
      checks++; if (div_clk !== exp_out(k, 8, 1)) begin errors++; $display("FAIL drop_neg k=%0d got=%b exp=%b", k, div_clk, exp_out(k, 8, 1)); end
    end
    for (int k = 8; k < 12; k++) begin
      tick();
      checks++; if (div_clk !== 1'b0) begin errors++; $display("FAIL drop_idle k=%0d got=%b exp=0", k, div_clk); end
      checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL drop_state k=%0d got=%0d exp=%0d", k, dbg_state, ST_IDLE); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL drop_locked k=%0d got=%b exp=0", k, locked); end
      half();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    div_ratio = 8'd10; clk_en = 1'b1;
    tick();
    half();
    tick();
    checks++; if (div_clk !== 1'b1) begin errors++; $display("FAIL rm_high got=%b exp=1", div_clk); end
    rst_n = 1'b0;
    #1;
    checks++; if (div_clk !== 1'b0) begin errors++; $display("FAIL rm_drop got=%b exp=0", div_clk); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rm_locked got=%b exp=0", locked); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rm_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    clk_en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (div_clk !== 1'b0) begin errors++; $display("FAIL rm_idle got=%b exp=0", div_clk); end
    clk_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++; if (div_clk !== exp_out(k % 10, 10, 0)) begin errors++; $display("FAIL rm10_pos k=%0d got=%b exp=%b", k, div_clk, exp_out(k % 10, 10, 0)); end
      half();
      checks++; if (div_clk !== exp_out(k % 10, 10, 1)) begin errors++; $display("FAIL rm10_neg k=%0d got=%b exp=%b", k, div_clk, exp_out(k % 10, 10, 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_ratio4();
    test_ratio5();
    test_ratio_change();
    test_bypass();
    test_en_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/int_clk_div.md
Name: int_clk_div

Overview:
- Runtime-programmable integer clock divider; parametrised successor to the fixed power-of-two ripple divider.
- Single synchronous counter clocked by i_clk; no ripple chain.
- Supports any ratio 1..2^RATIO_W-1, including odd ratios, plus bypass.
- Ratio changes and enable/disable take effect only at period boundaries. Sits at the clock-generation block output, feeding peripheral clock trees.

Parameters:
RATIO_W, 8, width of ratio input and internal counter; max ratio 2^RATIO_W-1

Ports:
i_clk  input  1  source clock
i_rst_n  input  1  asynchronous active-low reset
i_clk_en  input  1  divider enable; sampled on i_clk posedge
i_div_ratio  input  RATIO_W  requested division ratio; 0 and 1 both mean bypass
o_div_clk  output  1  divided clock
o_locked  output  1  high when running (RUN/BYPASS) and the active ratio equals i_div_ratio

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE, cnt=0, act_ratio=0, div_q=0, o_div_clk=0, o_locked=0.
- hi_len = act_ratio>>1 (floor).
- The ratio load (act_ratio <= i_div_ratio) happens only on IDLE exit and at period end.
- IDLE: o_div_clk=0.
  - Posedge with i_clk_en=1: load act_ratio.
  - Loaded ratio <=1: go to BYPASS.
  - Otherwise: go to RUN with cnt=0, div_q=1. First rising output edge is 1 i_clk cycle after en sampled.
- RUN:
  - Each posedge: cnt increments; div_q = (cnt_next < hi_len).
  - At cnt==act_ratio-1 (period end): cnt<=0.
  - Period end, i_clk_en=1: reload act_ratio; div_q<=1; go to BYPASS if the new ratio <=1.
  - Period end, i_clk_en=0: go to IDLE, div_q stays 0.
- Even N: high N/2, low N/2 cycles. Odd N (feature off): high (N-1)/2, low (N+1)/2.
- i_clk_en drop mid-period: the current period completes, then IDLE. Never truncate a phase.
- i_div_ratio change mid-period: ignored until period end. o_locked deasserts combinationally on mismatch and reasserts after the load.
- BYPASS: o_div_clk = i_clk.
  - Re-evaluated at every posedge.
  - i_clk_en=0: go to IDLE.
  - i_div_ratio>=2: load it and go to RUN with div_q=1. The output stays high across the switch, so no runt pulse.
- Output select (div_q vs i_clk): a dedicated mux cell whose select changes only at posedge. BYPASS->IDLE truncates that cycle's high phase; this is accepted and documented.
- Simultaneous en=0 and ratio change at period end: IDLE wins, act_ratio still loads.
- Reset mid-operation: immediate async return to reset values; o_div_clk drops to 0.
- Counter width RATIO_W; no overflow, since cnt < act_ratio <= 2^RATIO_W-1.

Optional Feature:
INT_CLK_DIV_ODD_DUTY50_EN
- Defined:
  - A negedge flop (async reset to 0) captures div_q.
  - For odd act_ratio, o_div_clk = div_q | div_neg_q, giving high exactly N/2 cycles (50% duty).
  - Even ratios and bypass are unchanged.
- Undefined: negedge flop absent; odd duty is (N-1)/2 : (N+1)/2.

Decomposition:
- Package int_clk_div_pkg:
  - state enum {IDLE, RUN, BYPASS}.
  - localparam for bypass threshold (1).
  - Function half_len(ratio).
- Sub-module clk_out_mux: output select plus the optional negedge duty-correction flop. Isolated so synthesis can map it to library clock cells.

Test Plan:
- Reset, then en=1, ratio=4 -> o_div_clk period 4 i_clk, high 2/low 2; o_locked=1 from 1 cycle after en sampled.
- ratio=5, feature off -> high 2, low 3 cycles. Feature on -> high 2.5, low 2.5 (check on negedge).
- ratio 6->3 at cnt=2 -> current period finishes as 6 cycles; next period is 3; o_locked low until the boundary.
- ratio=1 while running at 4 -> BYPASS at period end, o_div_clk==i_clk, no pulse <1 i_clk phase. Then ratio=2 -> RUN, period 2.
- en drops at cnt=1 with ratio=8 -> output completes high 4/low 4, then stays 0 (IDLE).
- Assert i_rst_n=0 mid-high phase at ratio=10 -> o_div_clk=0 immediately. After release + en -> restarts cleanly with period 10.
